// File: rtl/srlatch4_driver.sv
// Write sequencer for the SR latch bank: turns masked writes into S/R setup, En strobe, hold, release.
// Define SRLATCH4_DRIVER_READBACK_EN to add q_fb readback and the sticky mismatch flag.
module srlatch4_driver #(
  parameter int WIDTH      = 4,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic             clr,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] R,
  output logic             En,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shadow
`ifdef SRLATCH4_DRIVER_READBACK_EN
  ,
  input  logic [WIDTH-1:0] q_fb,
  output logic             mismatch
`endif
);

  localparam int MAXC_A = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAXC   = (MAXC_A > HOLD_CYC) ? MAXC_A : HOLD_CYC;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] LD_SETUP  = (SETUP_CYC > 0) ? CW'(SETUP_CYC - 1) : '0;
  localparam logic [CW-1:0] LD_STROBE = (STROBE_CYC > 0) ? CW'(STROBE_CYC - 1) : '0;
  localparam logic [CW-1:0] LD_HOLD   = (HOLD_CYC > 0) ? CW'(HOLD_CYC - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] acc_m;
  logic             accept;
  logic [WIDTH-1:0] shadow_next;

  // clr wins over wr_valid: capture an all-bits reset instead of the write.
  always_comb begin
    wr_ready    = (state == IDLE);
    accept      = wr_ready && (wr_valid || clr);
    acc_d       = clr ? '0 : wr_data;
    acc_m       = clr ? '1 : wr_mask;
    shadow_next = (shadow & ~m_q) | (d_q & m_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      d_q    <= '0;
      m_q    <= '0;
      S      <= '0;
      R      <= '0;
      En     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      shadow <= '0;
`ifdef SRLATCH4_DRIVER_READBACK_EN
      mismatch <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            d_q  <= acc_d;
            m_q  <= acc_m;
            S    <= acc_d & acc_m;
            R    <= ~acc_d & acc_m;
            busy <= 1'b1;
`ifdef SRLATCH4_DRIVER_READBACK_EN
            mismatch <= 1'b0;
`endif
            if (SETUP_CYC > 0) begin
              state <= SETUP;
              cnt   <= LD_SETUP;
            end else begin
              state <= STROBE;
              cnt   <= LD_STROBE;
              En    <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state <= STROBE;
            cnt   <= LD_STROBE;
            En    <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            En <= 1'b0;
            if (HOLD_CYC > 0) begin
              state <= HOLD;
              cnt   <= LD_HOLD;
            end else begin
              state  <= DONE;
              S      <= '0;
              R      <= '0;
              done   <= 1'b1;
              shadow <= shadow_next;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state  <= DONE;
            S      <= '0;
            R      <= '0;
            done   <= 1'b1;
            shadow <= shadow_next;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
`ifdef SRLATCH4_DRIVER_READBACK_EN
          if (((q_fb ^ d_q) & m_q) != '0) mismatch <= 1'b1;
`endif
        end
        default: begin
          state <= IDLE;
          S     <= '0;
          R     <= '0;
          En    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srlatch4_driver.sv
// Directed bench for srlatch4_driver: default timing instance plus a SETUP_CYC=0/HOLD_CYC=0 instance.
module tb_srlatch4_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid, clr;
  logic [3:0] wr_data, wr_mask;
  logic       wr_ready, En, busy, done;
  logic [3:0] S, R, shadow;

  logic       b_valid, b_clr;
  logic [3:0] b_data, b_mask;
  logic       b_ready, b_En, b_busy, b_done;
  logic [3:0] b_S, b_R, b_shadow;

`ifdef SRLATCH4_DRIVER_READBACK_EN
  logic [3:0] q_fb = 4'b0000;
  logic       mismatch, b_mismatch;
`endif

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  always #5 clk = ~clk;

  srlatch4_driver dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_mask(wr_mask), .clr(clr),
    .S(S), .R(R), .En(En), .busy(busy), .done(done), .shadow(shadow)
`ifdef SRLATCH4_DRIVER_READBACK_EN
    , .q_fb(q_fb), .mismatch(mismatch)
`endif
  );

  srlatch4_driver #(.WIDTH(4), .SETUP_CYC(0), .STROBE_CYC(2), .HOLD_CYC(0)) dut_fast (
    .clk(clk), .rst(rst), .wr_valid(b_valid), .wr_ready(b_ready),
    .wr_data(b_data), .wr_mask(b_mask), .clr(b_clr),
    .S(b_S), .R(b_R), .En(b_En), .busy(b_busy), .done(b_done), .shadow(b_shadow)
`ifdef SRLATCH4_DRIVER_READBACK_EN
    , .q_fb(q_fb), .mismatch(b_mismatch)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic [3:0] s, input logic [3:0] r,
                          input logic en, input logic bsy, input logic dn);
    chk({tag, ".S"}, 32'(S), 32'(s));
    chk({tag, ".R"}, 32'(R), 32'(r));
    chk({tag, ".En"}, 32'(En), 32'(en));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".ready"}, 32'(wr_ready), 32'(!bsy));
    chk({tag, ".SandR"}, 32'(S & R), 32'd0);
  endtask

  // Inputs must be set up for an accept at the next edge; ends in the IDLE cycle after done.
  task automatic seq_check(input string tag, input logic [3:0] s, input logic [3:0] r,
                           input logic [3:0] sh, input bit poke);
    tick();
    clr = 1'b0;
    chk_main({tag, ".c1"}, s, r, 1'b0, 1'b1, 1'b0);
    tick();
    if (poke) begin
      clr = 1'b1; wr_valid = 1'b1; wr_data = 4'b1111; wr_mask = 4'b1111;
    end
    chk_main({tag, ".c2"}, s, r, 1'b1, 1'b1, 1'b0);
    tick();
    chk_main({tag, ".c3"}, s, r, 1'b1, 1'b1, 1'b0);
    tick();
    if (poke) begin
      clr = 1'b0; wr_valid = 1'b0; wr_data = 4'b0000; wr_mask = 4'b0000;
    end
    chk_main({tag, ".c4"}, s, r, 1'b0, 1'b1, 1'b0);
    tick();
    chk_main({tag, ".c5"}, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
    tick();
    chk_main({tag, ".c6"}, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk({tag, ".shadow"}, 32'(shadow), 32'(sh));
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; clr = 1'b0; wr_data = '0; wr_mask = '0;
    b_valid = 1'b0; b_clr = 1'b0; b_data = '0; b_mask = '0;

    // Reset held 3 cycles
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk_main("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("reset.shadow", 32'(shadow), 32'd0);

    // Full-mask write
    wr_valid = 1'b1; wr_data = 4'b1010; wr_mask = 4'b1111;
    seq_check("wr1010", 4'b1010, 4'b0101, 4'b1010, 1'b0);
    wr_valid = 1'b0;

    // Partial mask; busy-time input changes must be ignored
    tick();
    wr_valid = 1'b1; wr_data = 4'b0101; wr_mask = 4'b0011;
    seq_check("wr0101m0011", 4'b0001, 4'b0010, 4'b1001, 1'b1);

    // clr and wr_valid together: clear runs first, write accepted after done
    tick();
    clr = 1'b1; wr_valid = 1'b1; wr_data = 4'b1111; wr_mask = 4'b1111;
    seq_check("clr", 4'b0000, 4'b1111, 4'b0000, 1'b0);
    seq_check("retry", 4'b1111, 4'b0000, 4'b1111, 1'b0);
    wr_valid = 1'b0;

    // Zero mask: strobe still runs, shadow unchanged
    tick();
    wr_valid = 1'b1; wr_data = 4'b0000; wr_mask = 4'b0000;
    seq_check("mask0", 4'b0000, 4'b0000, 4'b1111, 1'b0);
    wr_valid = 1'b0;

    // Reset during STROBE
    tick();
    wr_valid = 1'b1; wr_data = 4'b0011; wr_mask = 4'b1111;
    tick();
    wr_valid = 1'b0;
    chk_main("abort.c1", 4'b0011, 4'b1100, 1'b0, 1'b1, 1'b0);
    tick();
    chk_main("abort.c2", 4'b0011, 4'b1100, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk_main("abort.rst", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("abort.shadow", 32'(shadow), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_main("abort.after", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    end

    // SETUP_CYC=0, HOLD_CYC=0 instance: latency 3
    b_valid = 1'b1; b_data = 4'b0110; b_mask = 4'b0110;
    tick();
    b_valid = 1'b0;
    chk("fast.c1.En", 32'(b_En), 32'd1);
    chk("fast.c1.S", 32'(b_S), 32'h6);
    chk("fast.c1.R", 32'(b_R), 32'h0);
    chk("fast.c1.done", 32'(b_done), 32'd0);
    tick();
    chk("fast.c2.En", 32'(b_En), 32'd1);
    chk("fast.c2.done", 32'(b_done), 32'd0);
    tick();
    chk("fast.c3.En", 32'(b_En), 32'd0);
    chk("fast.c3.done", 32'(b_done), 32'd1);
    chk("fast.c3.S", 32'(b_S), 32'h0);
    chk("fast.c3.busy", 32'(b_busy), 32'd1);
    tick();
    chk("fast.c4.ready", 32'(b_ready), 32'd1);
    chk("fast.c4.shadow", 32'(b_shadow), 32'h6);
`ifdef SRLATCH4_DRIVER_READBACK_EN
    chk("fast.c4.mismatch", 32'(b_mismatch), 32'd1);
    tick();
    chk("fast.c5.mismatch", 32'(b_mismatch), 32'd1);
    b_valid = 1'b1; b_data = 4'b0000; b_mask = 4'b0000;
    tick();
    b_valid = 1'b0;
    chk("fast.reaccept.mismatch", 32'(b_mismatch), 32'd0);
    tick(); tick(); tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/srlatch4_driver.md
Name: srlatch4_driver

Overview:
Clocked write sequencer directly upstream of the 4-bit SR latch bank. Accepts masked write words over a valid/ready handshake and converts each into a safe S/R/En pulse sequence: S/R set up, enable strobed, S/R held, then released. Guarantees S and R are never both high on the same bit, so the latch bank never enters its forbidden state. Keeps a shadow copy of the expected latch contents for software and debug.

Parameters:
WIDTH, 4, number of latch bits driven
SETUP_CYC, 1, cycles S/R are stable before En rises; 0 allowed (state skipped)
STROBE_CYC, 2, cycles En is high; minimum 1
HOLD_CYC, 1, cycles S/R are held after En falls; 0 allowed (state skipped)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
wr_valid  input  1  write request
wr_ready  output  1  high when a request can be accepted
wr_data  input  WIDTH  target bit values
wr_mask  input  WIDTH  1 = update this bit, 0 = leave latch untouched
clr  input  1  request to reset all bits; sampled only when wr_ready is high
S  output  WIDTH  set lines to the latch bank
R  output  WIDTH  reset lines to the latch bank
En  output  1  latch enable strobe
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when a sequence completes
shadow  output  WIDTH  expected latch contents after the last completed write

Behaviour:
- Reset, synchronous: state = IDLE. S, R, En, busy, done and shadow are all 0. wr_ready = 1 in the cycle after rst is deasserted.
- States: IDLE -> SETUP -> STROBE -> HOLD -> DONE -> IDLE. A down-counter sized for max(SETUP_CYC, STROBE_CYC, HOLD_CYC) is loaded on each state entry.
- wr_ready = (state == IDLE). An accept happens on a clock edge where wr_ready=1 and either wr_valid=1 or clr=1.
- clr has priority over wr_valid in the same cycle. When clr wins, the captured data is all 0s, the captured mask is all 1s, and the wr_valid request is not accepted (wr_ready drops, so the requester retries).
- On accept, register data d and mask m, then enter SETUP. If SETUP_CYC = 0, go straight to STROBE.
- S = d & m and R = ~d & m during SETUP, STROBE and HOLD. In IDLE and DONE, S = R = 0.
- Invariant: (S & R) == 0 on every cycle, including reset.
- En = 1 only in STROBE, for exactly STROBE_CYC cycles.
- HOLD lasts HOLD_CYC cycles. If HOLD_CYC = 0, STROBE goes directly to DONE.
- DONE lasts 1 cycle: done = 1, and shadow <= (shadow & ~m) | (d & m) takes effect on this edge. Next state is IDLE.
- Latency: accept edge to done pulse = SETUP_CYC + STROBE_CYC + HOLD_CYC + 1 cycles. A new accept is possible on the edge after DONE, so throughput is one write per (latency + 1) cycles.
- A mask of all 0s still runs the full sequence. En pulses with S = R = 0, the latches hold, and shadow is unchanged.
- wr_data, wr_mask and clr are ignored while busy. Inputs are sampled only at accept.
- rst asserted mid-sequence aborts immediately: outputs return to reset values on the next edge. shadow is cleared to 0 even though the physical latches may retain data; software must issue clr after reset.

Optional Feature:
Macro SRLATCH4_DRIVER_READBACK_EN.
- Defined:
  - Adds input q_fb (WIDTH bits, the latch Q outputs) and output mismatch (1 bit, sticky).
  - In DONE, if ((q_fb ^ d) & m) != 0, mismatch is set to 1.
  - mismatch is cleared by rst or by the next accept.
- Undefined: neither port exists and no check logic is built.

Test Plan:
- rst held 3 cycles, then released -> S=R=0, En=0, shadow=0, busy=0, wr_ready=1 on the next cycle.
- Defaults, write d=4'b1010, m=4'b1111 -> S=1010, R=0101 for 4 cycles; En high for cycles 2-3 only; done pulses 5 cycles after accept; shadow=1010.
- From shadow=1010, write d=4'b0101, m=4'b0011 -> S=0001, R=0010; shadow=1001; bits 3:2 have S=R=0 throughout.
- clr and wr_valid both high in IDLE with d=4'b1111 -> clear sequence runs with R=1111, S=0000; shadow=0000; the write is accepted only after done.
- rst pulsed during STROBE -> S, R and En drop to 0 on the next edge; state returns to IDLE; done never pulses; shadow=0.
- SETUP_CYC=0, HOLD_CYC=0 build with readback enabled and q_fb forced to 0000, write d=4'b0110, m=4'b0110 -> En rises on the edge after accept; done fires 3 cycles after accept; mismatch=1 until the next accept.
